descriptor_tx: RTL and testbench
================================

Name: descriptor_tx

Overview:
- Transmit-side counterpart of the TTI RX descriptor path. Serves controller-issued Private Reads.
- Pops one TX descriptor (byte count) from the TTI TX descriptor queue, then streams that many bytes from the TTI TX data queue to the target FSM, marking the last byte.
- On controller early termination, drains the unsent remainder of the descriptor's bytes from the data queue.
- Reports per-transfer completion status.

Parameters:
- TtiTxDescDataWidth, 32, TX descriptor width; bits [15:0] = data length in bytes, other bits ignored.
- TtiTxDataWidth, 8, TX data queue width; one byte per entry.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- tti_tx_desc_queue_rvalid_i  in  1  descriptor available
- tti_tx_desc_queue_rready_o  out  1  descriptor pop
- tti_tx_desc_queue_rdata_i  in  TtiTxDescDataWidth  descriptor
- tti_tx_queue_rvalid_i  in  1  data byte available
- tti_tx_queue_rready_o  out  1  data byte pop
- tti_tx_queue_rdata_i  in  TtiTxDataWidth  data byte
- tx_desc_avail_o  out  1  a transfer is loaded; FSM may ACK the read header
- tx_byte_o  out  8  byte to target FSM
- tx_byte_valid_o  out  1  byte valid
- tx_byte_ready_i  in  1  FSM accepts byte
- tx_byte_last_o  out  1  current byte is the final byte of the descriptor
- tx_byte_err_i  in  1  controller terminated the read early; one-cycle pulse
- tx_done_o  out  1  one-cycle pulse at transfer end
- tx_sent_cnt_o  out  16  bytes delivered in the finished transfer; valid with tx_done_o, held until the next done
- tx_aborted_o  out  1  finished transfer was terminated early; valid with tx_done_o

Behaviour:
- Reset (async assert, clean release on a clock edge):
  - State IDLE; remaining and sent counters 0.
  - All outputs 0, including tx_sent_cnt_o and tx_aborted_o.
  - Reset mid-transfer abandons the transfer with no done pulse and no drain.
- FSM states: IDLE, SEND, DRAIN.
- IDLE:
  - tti_tx_desc_queue_rready_o=1; all else idle.
  - On rvalid: latch len=rdata[15:0] and clear sent.
  - len>0: go to SEND on the next cycle, so the first byte can be offered one cycle after the descriptor pop.
  - len=0: stay in IDLE and pulse tx_done_o next cycle with sent=0, aborted=0. No data is popped.
- SEND:
  - tx_desc_avail_o=1.
  - tx_byte_o=tti_tx_queue_rdata_i, tx_byte_valid_o=tti_tx_queue_rvalid_i, tti_tx_queue_rready_o=tx_byte_ready_i. This is a combinational pass-through with zero added latency.
  - tx_byte_last_o = (remaining==1) & tx_byte_valid_o.
  - Handshake (valid&ready): remaining-1, sent+1 (16-bit, no wrap possible since sent<=len).
  - Handshake with remaining==1: go to IDLE; tx_done_o pulses next cycle with aborted=0.
  - Data queue empty: valid low, no state change. The FSM handles the underrun; no timeout in this block.
- Early termination (tx_byte_err_i in SEND):
  - A handshake in the same cycle counts as delivered.
  - If remaining after that cycle is 0: transfer ends in IDLE with aborted=1.
  - Otherwise go to DRAIN with aborted flagged.
- DRAIN:
  - tx_byte_valid_o=0, tti_tx_queue_rready_o=1, tti_tx_desc_queue_rready_o=0.
  - Each data pop decrements remaining; sent is unchanged.
  - At the pop with remaining==1: go to IDLE; tx_done_o pulses next cycle with aborted=1.
  - If the data queue stays empty, DRAIN waits indefinitely.
- tx_byte_err_i outside SEND is ignored.
- At most one descriptor is in flight. The next descriptor is popped no earlier than the cycle after return to IDLE.

Optional Feature:
- Macro DESCRIPTOR_TX_ABORT_CNT_EN.
- Defined:
  - Adds output port tx_abort_cnt_o [7:0], a saturating count (holds at 255) of transfers completed with aborted=1.
  - Increments on the tx_done_o cycle; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Descriptor len=4, data 0xA1..0xA4, ready always 1 -> bytes A1,A2,A3,A4 on consecutive cycles; last high only with A4; done pulse sent=4, aborted=0; data queue empty afterwards.
- Same len=4, ready toggled 1/0 and data rvalid gapped -> byte order preserved; no byte duplicated or skipped; sent=4.
- len=6, err asserted on the handshake of byte 2 -> 4 remaining bytes popped in DRAIN with tx_byte_valid_o=0; done sent=2, aborted=1; next descriptor's first byte is correct. With DESCRIPTOR_TX_ABORT_CNT_EN defined, tx_abort_cnt_o=1.
- len=0 descriptor followed by len=1 (0x5C) -> first done sent=0 with no data pop; then 0x5C delivered with last=1; second done sent=1.
- Reset asserted mid-SEND of len=8 after 3 bytes -> outputs 0 immediately (async); after release, IDLE pops the next descriptor; no done pulse for the interrupted transfer.

Source files
------------

// File: rtl/descriptor_tx.sv
// descriptor_tx
//   Serves controller-issued Private Reads. It pops one TX descriptor (a byte
//   count in bits [15:0]) and then streams that many bytes from the TTI TX data
//   queue to the target FSM, flagging the final byte. If the controller ends
//   the read early, the unsent remainder is drained from the data queue so the
//   next descriptor starts on its own data. Every finished transfer produces a
//   one-cycle done pulse together with its delivered-byte count and abort flag.
//
//   Optional build macro: DESCRIPTOR_TX_ABORT_CNT_EN adds tx_abort_cnt_o, a
//   saturating count of aborted transfers.
//
//   Ports
//     clk_i, rst_i                 clock, async active-high reset
//     tti_tx_desc_queue_*          descriptor queue read side (valid/ready/data)
//     tti_tx_queue_*               data queue read side, one byte per entry
//     tx_desc_avail_o              transfer loaded, target FSM may ACK header
//     tx_byte_o/_valid_o/_ready_i  byte stream to the target FSM
//     tx_byte_last_o               current byte is the descriptor's final byte
//     tx_byte_err_i                controller early-termination pulse
//     tx_done_o                    one-cycle pulse at transfer end
//     tx_sent_cnt_o, tx_aborted_o  status of the last finished transfer
//
//   state | meaning
//   IDLE  | waiting for a descriptor; descriptor queue ready
//   SEND  | passing data bytes through to the target FSM
//   DRAIN | discarding the unsent remainder after early termination
module descriptor_tx #(
    parameter int TtiTxDescDataWidth = 32,
    parameter int TtiTxDataWidth     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tti_tx_desc_queue_rvalid_i,
    output logic                          tti_tx_desc_queue_rready_o,
    input  logic [TtiTxDescDataWidth-1:0] tti_tx_desc_queue_rdata_i,
    input  logic                          tti_tx_queue_rvalid_i,
    output logic                          tti_tx_queue_rready_o,
    input  logic [TtiTxDataWidth-1:0]     tti_tx_queue_rdata_i,
    output logic                          tx_desc_avail_o,
    output logic [7:0]                    tx_byte_o,
    output logic                          tx_byte_valid_o,
    input  logic                          tx_byte_ready_i,
    output logic                          tx_byte_last_o,
    input  logic                          tx_byte_err_i,
    output logic                          tx_done_o,
    output logic [15:0]                   tx_sent_cnt_o,
    output logic                          tx_aborted_o
`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
   ,output logic [7:0]                    tx_abort_cnt_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] sent_q, sent_d;
    logic        done_q, done_d;
    logic [15:0] sent_out_q, sent_out_d;
    logic        aborted_out_q, aborted_out_d;
    logic [15:0] rem_after;
    logic [15:0] sent_after;
    logic        in_idle, in_send, in_drain;
    logic        handshake;
    logic        unused_desc_bits;

    assign unused_desc_bits = ^tti_tx_desc_queue_rdata_i[TtiTxDescDataWidth-1:16];

    assign in_idle  = (state_q == IDLE);
    assign in_send  = (state_q == SEND);
    assign in_drain = (state_q == DRAIN);

    // Descriptor ready is gated by reset so every output reads 0 while held in reset.
    assign tti_tx_desc_queue_rready_o = in_idle & ~rst_i;
    assign tti_tx_queue_rready_o      = (in_send & tx_byte_ready_i) | in_drain;
    assign tx_desc_avail_o            = in_send;
    assign tx_byte_o                  = in_send ? tti_tx_queue_rdata_i[7:0] : 8'h00;
    assign tx_byte_valid_o            = in_send & tti_tx_queue_rvalid_i;
    assign tx_byte_last_o             = tx_byte_valid_o & (remaining_q == 16'd1);
    assign handshake                  = tx_byte_valid_o & tx_byte_ready_i;

    assign tx_done_o     = done_q;
    assign tx_sent_cnt_o = sent_out_q;
    assign tx_aborted_o  = aborted_out_q;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        sent_d        = sent_q;
        done_d        = 1'b0;
        sent_out_d    = sent_out_q;
        aborted_out_d = aborted_out_q;
        rem_after     = handshake ? remaining_q - 16'd1 : remaining_q;
        sent_after    = handshake ? sent_q + 16'd1 : sent_q;
        case (state_q)
            IDLE: begin
                if (tti_tx_desc_queue_rvalid_i) begin
                    remaining_d = tti_tx_desc_queue_rdata_i[15:0];
                    sent_d      = 16'd0;
                    if (tti_tx_desc_queue_rdata_i[15:0] == 16'd0) begin
                        done_d        = 1'b1;
                        sent_out_d    = 16'd0;
                        aborted_out_d = 1'b0;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                remaining_d = rem_after;
                sent_d      = sent_after;
                // A byte accepted in the termination cycle still counts as delivered.
                if (tx_byte_err_i) begin
                    if (rem_after == 16'd0) begin
                        state_d       = IDLE;
                        done_d        = 1'b1;
                        sent_out_d    = sent_after;
                        aborted_out_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (handshake && remaining_q == 16'd1) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    sent_out_d    = sent_after;
                    aborted_out_d = 1'b0;
                end
            end
            DRAIN: begin
                if (tti_tx_queue_rvalid_i) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d       = IDLE;
                        done_d        = 1'b1;
                        sent_out_d    = sent_q;
                        aborted_out_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            remaining_q   <= 16'd0;
            sent_q        <= 16'd0;
            done_q        <= 1'b0;
            sent_out_q    <= 16'd0;
            aborted_out_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            sent_q        <= sent_d;
            done_q        <= done_d;
            sent_out_q    <= sent_out_d;
            aborted_out_q <= aborted_out_d;
        end
    end

`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;

    // Updated on the edge that raises tx_done_o, so the new count is visible with the pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            abort_cnt_q <= 8'd0;
        end else if (done_d && aborted_out_d && abort_cnt_q != 8'hFF) begin
            abort_cnt_q <= abort_cnt_q + 8'd1;
        end
    end

    assign tx_abort_cnt_o = abort_cnt_q;
`endif

endmodule

// File: tb/tb_descriptor_tx.sv
module tb_descriptor_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_v = 1'b0;
    logic [31:0] desc_d = '0;
    logic        q_v = 1'b0;
    logic [7:0]  q_d = '0;
    logic        rdy = 1'b0;
    logic        err = 1'b0;

    logic        desc_rdy, q_rdy, avail, bv, last, done, ab;
    logic [7:0]  b;
    logic [15:0] sent;
`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
    logic [7:0]  abort_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    descriptor_tx dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .tti_tx_desc_queue_rvalid_i (desc_v),
        .tti_tx_desc_queue_rready_o (desc_rdy),
        .tti_tx_desc_queue_rdata_i  (desc_d),
        .tti_tx_queue_rvalid_i      (q_v),
        .tti_tx_queue_rready_o      (q_rdy),
        .tti_tx_queue_rdata_i       (q_d),
        .tx_desc_avail_o            (avail),
        .tx_byte_o                  (b),
        .tx_byte_valid_o            (bv),
        .tx_byte_ready_i            (rdy),
        .tx_byte_last_o             (last),
        .tx_byte_err_i              (err),
        .tx_done_o                  (done),
        .tx_sent_cnt_o              (sent),
        .tx_aborted_o               (ab)
`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
       ,.tx_abort_cnt_o             (abort_cnt)
`endif
    );

    typedef struct {
        logic        dv;
        logic [31:0] dd;
        logic        qv;
        logic [7:0]  qd;
        logic        rdy;
        logic        err;
        logic        e_drdy;
        logic        e_qrdy;
        logic        e_av;
        logic        e_bv;
        logic [7:0]  e_b;
        logic        e_last;
        logic        e_done;
        logic [15:0] e_sent;
        logic        e_ab;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_desc_rdy"}, {31'd0, desc_rdy}, 32'd0);
        chk({tag, "_q_rdy"},    {31'd0, q_rdy},    32'd0);
        chk({tag, "_avail"},    {31'd0, avail},    32'd0);
        chk({tag, "_bv"},       {31'd0, bv},       32'd0);
        chk({tag, "_byte"},     {24'd0, b},        32'd0);
        chk({tag, "_last"},     {31'd0, last},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_sent"},     {16'd0, sent},     32'd0);
        chk({tag, "_ab"},       {31'd0, ab},       32'd0);
    endtask

    // Drive one cycle's inputs on the falling edge, then compare the settled outputs.
    task automatic apply(input vec_t v, input int idx);
        string t;
        @(negedge clk);
        desc_v = v.dv; desc_d = v.dd; q_v = v.qv; q_d = v.qd; rdy = v.rdy; err = v.err;
        #1;
        t = $sformatf("vec%0d", idx);
        chk({t, "_desc_rdy"}, {31'd0, desc_rdy}, {31'd0, v.e_drdy});
        chk({t, "_q_rdy"},    {31'd0, q_rdy},    {31'd0, v.e_qrdy});
        chk({t, "_avail"},    {31'd0, avail},    {31'd0, v.e_av});
        chk({t, "_bv"},       {31'd0, bv},       {31'd0, v.e_bv});
        if (v.e_bv) chk({t, "_byte"}, {24'd0, b}, {24'd0, v.e_b});
        chk({t, "_last"},     {31'd0, last},     {31'd0, v.e_last});
        chk({t, "_done"},     {31'd0, done},     {31'd0, v.e_done});
        chk({t, "_sent"},     {16'd0, sent},     {16'd0, v.e_sent});
        chk({t, "_ab"},       {31'd0, ab},       {31'd0, v.e_ab});
    endtask

    function automatic vec_t mk(logic dv, logic [31:0] dd, logic qv, logic [7:0] qd, logic r, logic e,
                                logic edr, logic eqr, logic eav, logic ebv, logic [7:0] eb,
                                logic el, logic edn, logic [15:0] es, logic eab);
        vec_t v;
        v.dv = dv; v.dd = dd; v.qv = qv; v.qd = qd; v.rdy = r; v.err = e;
        v.e_drdy = edr; v.e_qrdy = eqr; v.e_av = eav; v.e_bv = ebv; v.e_b = eb;
        v.e_last = el; v.e_done = edn; v.e_sent = es; v.e_ab = eab;
        return v;
    endfunction

    initial begin
        logic [7:0] qm[$];
        logic [7:0] exp_bytes[4];
        int idx;
        int cyc;
        bit done_seen;
        logic [15:0] done_sent;

        // Reset state
        #3;
        chk_idle_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // len=4, A1..A4, ready always high
        vq.push_back(mk(1, 32'd4, 1, 8'hA1, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hA1, 1, 0,  0, 1, 1, 1, 8'hA1, 0, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hA2, 1, 0,  0, 1, 1, 1, 8'hA2, 0, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hA3, 1, 0,  0, 1, 1, 1, 8'hA3, 0, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hA4, 1, 0,  0, 1, 1, 1, 8'hA4, 1, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 1, 16'd4, 0));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd4, 0));
        // len=0 (no data pop) then len=1 with junk upper descriptor bits
        vq.push_back(mk(1, 32'd0, 1, 8'h5C, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd4, 0));
        vq.push_back(mk(1, 32'hFFFF_0001, 1, 8'h5C, 1, 0,  1, 0, 0, 0, 8'h00, 0, 1, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'h5C, 1, 0,  0, 1, 1, 1, 8'h5C, 1, 0, 16'd0, 0));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 1, 16'd1, 0));
        // len=6, err on byte 2, drain 4 with a gap, then len=1
        vq.push_back(mk(1, 32'd6, 1, 8'hB1, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB1, 1, 0,  0, 1, 1, 1, 8'hB1, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB2, 1, 1,  0, 1, 1, 1, 8'hB2, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB3, 1, 1,  0, 1, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB4, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB5, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hB6, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(1, 32'd1, 1, 8'hC7, 1, 1,  1, 0, 0, 0, 8'h00, 0, 1, 16'd2, 1));
        vq.push_back(mk(0, 32'd0, 1, 8'hC7, 1, 0,  0, 1, 1, 1, 8'hC7, 1, 0, 16'd2, 1));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 1, 1,  1, 0, 0, 0, 8'h00, 0, 1, 16'd1, 0));
        // len=2, err together with the final handshake -> ends in IDLE, aborted
        vq.push_back(mk(1, 32'd2, 1, 8'hD1, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hD1, 1, 0,  0, 1, 1, 1, 8'hD1, 0, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 1, 8'hD2, 1, 1,  0, 1, 1, 1, 8'hD2, 1, 0, 16'd1, 0));
        vq.push_back(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 1, 16'd2, 1));

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
        chk("abort_cnt", {24'd0, abort_cnt}, 32'd2);
`endif

        // len=4 with toggling ready and gapped data valid
        exp_bytes = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        qm = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        idx = 0;
        done_seen = 0;
        done_sent = '0;
        cyc = 0;
        while (!done_seen && cyc < 60) begin
            @(negedge clk);
            err    = 1'b0;
            desc_v = (cyc == 0);
            desc_d = 32'd4;
            rdy    = cyc[0];
            q_v    = (qm.size() > 0) && (cyc % 3 != 2);
            q_d    = (qm.size() > 0) ? qm[0] : 8'h00;
            #1;
            if (bv && rdy) begin
                if (idx < 4) begin
                    chk($sformatf("gap_byte%0d", idx), {24'd0, b}, {24'd0, exp_bytes[idx]});
                    chk($sformatf("gap_last%0d", idx), {31'd0, last}, {31'd0, (idx == 3)});
                end else begin
                    chk("gap_extra_byte", 32'd1, 32'd0);
                end
                idx++;
            end
            if (q_rdy && q_v) void'(qm.pop_front());
            if (done) begin
                done_seen = 1;
                done_sent = sent;
            end
            cyc++;
        end
        chk("gap_done_seen", {31'd0, done_seen}, 32'd1);
        chk("gap_sent", {16'd0, done_sent}, 32'd4);
        chk("gap_aborted", {31'd0, ab}, 32'd0);
        chk("gap_byte_count", idx, 32'd4);
        chk("gap_queue_empty", qm.size(), 32'd0);

        // Reset in the middle of a len=8 transfer after 3 bytes
        apply(mk(1, 32'd8, 1, 8'hF0, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd4, 0), 100);
        apply(mk(0, 32'd0, 1, 8'hF0, 1, 0,  0, 1, 1, 1, 8'hF0, 0, 0, 16'd4, 0), 101);
        apply(mk(0, 32'd0, 1, 8'hF1, 1, 0,  0, 1, 1, 1, 8'hF1, 0, 0, 16'd4, 0), 102);
        apply(mk(0, 32'd0, 1, 8'hF2, 1, 0,  0, 1, 1, 1, 8'hF2, 0, 0, 16'd4, 0), 103);
        apply(mk(0, 32'd0, 1, 8'hF3, 1, 0,  0, 1, 1, 1, 8'hF3, 0, 0, 16'd4, 0), 104);
        #1;
        rst = 1'b1;
        #1;
        chk_idle_zero("rst_async");
        @(negedge clk);
        #1;
        chk_idle_zero("rst_held");
`ifdef DESCRIPTOR_TX_ABORT_CNT_EN
        chk("abort_cnt_rst", {24'd0, abort_cnt}, 32'd0);
`endif
        rst = 1'b0;
        apply(mk(1, 32'd1, 1, 8'h3D, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd0, 0), 105);
        apply(mk(0, 32'd0, 1, 8'h3D, 1, 0,  0, 1, 1, 1, 8'h3D, 1, 0, 16'd0, 0), 106);
        apply(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 1, 16'd1, 0), 107);
        apply(mk(0, 32'd0, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00, 0, 0, 16'd1, 0), 108);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
